// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the two-requester UART TX/RX arbiter.
// Optional round-robin arbitration is selected by defining UART_ARB_RR_EN.
package uart_arb_pkg;

    localparam int unsigned SYNC_STAGES       = 2;
    localparam int unsigned DEF_STROBE_CYCLES = 2;
    localparam int unsigned DEF_BUSY_TIMEOUT  = 8;
    localparam int unsigned DATA_W            = 8;
    localparam int unsigned CNT_W             = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STROBE    = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single-bit asynchronous input.
module sync2
    import uart_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_arbiter.sv
// Arbitrates two byte requesters onto one UART TX port and buffers one RX byte.
// Define UART_ARB_RR_EN for round-robin arbitration; otherwise req0 has fixed priority.
module uart_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = DEF_STROBE_CYCLES,
    parameter int unsigned BUSY_TIMEOUT  = DEF_BUSY_TIMEOUT
) (
    input  logic              sclk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic              grant,
    output logic              uart_ss,
    output logic [DATA_W-1:0] uart_data,
    input  logic              uart_busy,
    input  logic [DATA_W-1:0] uart_rec_data,
    input  logic              uart_rec_valid,
    output logic              uart_rr,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    input  logic              rx_ack,
    output logic              rx_overrun,
    output logic              tx_timeout
);

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ss_q, ss_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              grant_q, grant_d;
    logic              timeout_q, timeout_d;
    logic              rv_prev_q, rv_prev_d;
    logic              rr_q, rr_d;
    logic              rx_valid_q, rx_valid_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              overrun_q, overrun_d;
`ifdef UART_ARB_RR_EN
    logic              last_q, last_d;
`endif

    logic busy_s, rv_s;
    logic win1, idle_ok, take, rv_edge;

    sync2 u_sync_busy (.clk_i(sclk), .rst_ni(reset), .d_i(uart_busy),      .q_o(busy_s));
    sync2 u_sync_rv   (.clk_i(sclk), .rst_ni(reset), .d_i(uart_rec_valid), .q_o(rv_s));

    // Winner selection; ready is gated by reset so it is low while reset is held.
    always_comb begin
`ifdef UART_ARB_RR_EN
        win1 = req1_valid && (!req0_valid || !last_q);
`else
        win1 = req1_valid && !req0_valid;
`endif
        idle_ok    = reset && (state_q == ST_IDLE);
        req0_ready = idle_ok && req0_valid && !win1;
        req1_ready = idle_ok && win1;
        take       = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

    // TX next-state and registered outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ss_d      = ss_q;
        data_d    = data_q;
        grant_d   = grant_q;
        timeout_d = 1'b0;
`ifdef UART_ARB_RR_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_STROBE;
                    ss_d    = 1'b1;
                    cnt_d   = '0;
                    data_d  = win1 ? req1_data : req0_data;
                    grant_d = win1;
`ifdef UART_ARB_RR_EN
                    last_d  = win1;
`endif
                end
            end
            ST_STROBE: begin
                if (cnt_q == CNT_W'(STROBE_CYCLES - 1)) begin
                    state_d = ST_WAIT_BUSY;
                    ss_d    = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_BUSY: begin
                if (busy_s) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == CNT_W'(BUSY_TIMEOUT - 1)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RX capture: an edge while a byte is still unacknowledged only flags overrun
    always_comb begin
        rv_edge    = rv_s && !rv_prev_q;
        rv_prev_d  = rv_s;
        rr_d       = rv_edge;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        overrun_d  = overrun_q;
        if (rv_edge) begin
            if (rx_valid_q && !rx_ack) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d  = uart_rec_data;
                rx_valid_d = 1'b1;
            end
        end else if (rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ss_q       <= 1'b0;
            data_q     <= '0;
            grant_q    <= 1'b0;
            timeout_q  <= 1'b0;
            rv_prev_q  <= 1'b0;
            rr_q       <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            overrun_q  <= 1'b0;
`ifdef UART_ARB_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ss_q       <= ss_d;
            data_q     <= data_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
            rv_prev_q  <= rv_prev_d;
            rr_q       <= rr_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            overrun_q  <= overrun_d;
`ifdef UART_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign uart_ss    = ss_q;
    assign uart_data  = data_q;
    assign grant      = grant_q;
    assign tx_timeout = timeout_q;
    assign uart_rr    = rr_q;
    assign rx_valid   = rx_valid_q;
    assign rx_data    = rx_data_q;
    assign rx_overrun = overrun_q;

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 The block SHALL have parameter STROBE_CYCLES, default 2, giving the number of sclk cycles uart_ss is held high per byte (range 1-15).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 8, giving the maximum sclk cycles to wait for synchronised busy to rise (range 2-255).
REQ-003 The block SHALL use clock sclk (input, 1): all flops clock on its rising edge.
REQ-004 The block SHALL use reset reset (input, 1): asynchronous, active-low.
REQ-005 The block SHALL have req0_valid (input, 1), req0_data (input, 8) and req0_ready (output, 1): requester 0 TX handshake.
REQ-006 The block SHALL have req1_valid (input, 1), req1_data (input, 8) and req1_ready (output, 1): requester 1 TX handshake.
REQ-007 The block SHALL have grant (output, 1): index of the requester owning the byte in flight.
REQ-008 The block SHALL have uart_ss (output, 1) and uart_data (output, 8): send strobe and byte to the UART.
REQ-009 The block SHALL have uart_busy (input, 1): UART TX busy, asynchronous to sclk.
REQ-010 The block SHALL have uart_rec_data (input, 8), uart_rec_valid (input, 1, asynchronous) and uart_rr (output, 1): UART receive path.
REQ-011 The block SHALL have rx_valid (output, 1), rx_data (output, 8) and rx_ack (input, 1): consumer RX handshake.
REQ-012 The block SHALL have rx_overrun (output, 1), a sticky flag, and tx_timeout (output, 1), a 1-cycle pulse.

Function
REQ-013 The TX FSM SHALL have four states: IDLE, STROBE, WAIT_BUSY and WAIT_DONE.
REQ-014 In IDLE with at least one reqN_valid, the arbiter SHALL assert the winner's reqN_ready combinationally for one cycle; transfer occurs on valid&ready.
REQ-015 On transfer, the block SHALL register reqN_data into uart_data, set grant, and move to STROBE on the next cycle. uart_data SHALL be held stable until the FSM returns to IDLE.
REQ-016 In STROBE, uart_ss SHALL be high for exactly STROBE_CYCLES cycles, then the FSM SHALL move to WAIT_BUSY.
REQ-017 In WAIT_BUSY, synchronised busy=1 SHALL move the FSM to WAIT_DONE. If BUSY_TIMEOUT cycles elapse without it, the block SHALL pulse tx_timeout and return to IDLE.
REQ-018 In WAIT_DONE, synchronised busy=0 SHALL move the FSM to IDLE.
REQ-019 No reqN_ready SHALL assert outside IDLE. The earliest new grant is the first cycle in IDLE.
REQ-020 uart_busy and uart_rec_valid SHALL each pass through a 2-flop synchroniser before use.
REQ-021 A rising edge of synchronised rec_valid SHALL, in the same cycle: capture uart_rec_data into rx_data, set rx_valid, and pulse uart_rr high for exactly 1 cycle.
REQ-022 rx_ack while rx_valid=1 SHALL clear rx_valid and rx_overrun on the next cycle.
REQ-023 If a new receive edge arrives while rx_valid=1 and rx_ack=0, the block SHALL keep the old rx_data, set rx_overrun, and still pulse uart_rr.
REQ-024 If rx_ack and a receive edge occur in the same cycle, the block SHALL capture the new byte, keep rx_valid=1, and leave rx_overrun unchanged.
REQ-025 The TX and RX paths SHALL operate independently and concurrently.

Reset
REQ-026 Reset SHALL force: FSM=IDLE, uart_ss=0, uart_data=0, grant=0, reqN_ready=0, uart_rr=0, rx_valid=0, rx_data=0, rx_overrun=0, tx_timeout=0, synchronisers=0, RR pointer favouring req0.
REQ-027 Reset asserted mid-byte SHALL abort the byte immediately; uart_ss SHALL drop asynchronously.

Configuration
REQ-028 With UART_ARB_RR_EN defined, arbitration SHALL be round-robin: when both requesters are valid, the one not granted last wins.
REQ-029 Without UART_ARB_RR_EN, arbitration SHALL be fixed priority: req0 always wins when valid. The RR pointer flop SHALL be absent.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the TX state enum typedef, SYNC_STAGES=2, and the default STROBE_CYCLES/BUSY_TIMEOUT constants.
REQ-031 Sub-module sync2 (2-flop synchroniser, async active-low reset) SHALL be instantiated twice; all other logic stays in uart_arbiter.

Verification
REQ-032 Only req0 valid with 0x55: req0_ready 1 cycle; uart_data=0x55; uart_ss high 2 cycles; busy model 1 for 100 cycles; FSM returns to IDLE 2-3 cycles after busy falls.
REQ-033 req0 and req1 both valid continuously, with UART_ARB_RR_EN defined: grants alternate 0,1,0,1. Without UART_ARB_RR_EN: grant always 0.
REQ-034 uart_busy tied 0: tx_timeout pulses once 8 cycles after entering WAIT_BUSY; the next request is then accepted.
REQ-035 rec_valid rises with 0xA3, no rx_ack: rx_data=0xA3, uart_rr 1-cycle pulse. A second byte 0x11 arrives: rx_data stays 0xA3, rx_overrun=1. rx_ack clears both.
REQ-036 reset asserted during STROBE: uart_ss=0 immediately, all outputs at reset values. After release, a new request completes normally.
